// File: rtl/cache_port.sv
// cache_port: CPU load/store port onto a word-wide cache.
// Unaligned accesses that cross a word boundary are split into two cache phases.
module cache_port (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        cache_enable,
   output logic [31:0] cache_address,
   output logic [31:0] cache_data_in,
   output logic [3:0]  cache_write_enable,
   input  logic [31:0] cache_data_out,
   input  logic        cache_data_out_ready,
   input  logic        cache_busy
);
   typedef enum logic [2:0] {IDLE, ISSUE1, CHECK1, ISSUE2, CHECK2, RESP} state_t;
   state_t      state;
   logic [31:0] addr, wdata, word1;
   logic        write, uns;
   logic [1:0]  size;
   logic [3:0]  base;
   logic [7:0]  mask;
   logic [63:0] data;
   logic        split;
   logic        unused;

   // data is used as captured whether or not the cache flags it ready
   assign unused = cache_data_out_ready;
   assign base   = size == 2'd0 ? 4'b0001 : size == 2'd1 ? 4'b0011 : 4'b1111;
   assign mask   = {4'b0000, base} << addr[1:0];
   assign data   = {32'b0, wdata} << {addr[1:0], 3'b000};
   assign split  = |mask[7:4];

   function automatic logic [31:0] extract(input logic [63:0] line);
      logic [31:0] w;
      w = 32'(line >> {addr[1:0], 3'b000});
      return size == 2'd0 ? {uns ? 24'b0 : {24{w[7]}}, w[7:0]} :
             size == 2'd1 ? {uns ? 16'b0 : {16{w[15]}}, w[15:0]} : w;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         req_ready          <= 1'b1;
         rsp_valid          <= 1'b0;
         rsp_rdata          <= '0;
         cache_enable       <= 1'b0;
         cache_address      <= '0;
         cache_data_in      <= '0;
         cache_write_enable <= '0;
         addr               <= '0;
         wdata              <= '0;
         word1              <= '0;
         write              <= 1'b0;
         uns                <= 1'b0;
         size               <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               addr          <= req_addr;
               wdata         <= req_wdata;
               write         <= req_write;
               size          <= req_size;
               uns           <= req_unsigned;
               req_ready     <= 1'b0;
               cache_address <= {req_addr[31:2], 2'b00};
               state         <= ISSUE1;
            end
            ISSUE1: begin
               cache_enable       <= 1'b1;
               cache_write_enable <= write ? mask[3:0] : 4'b0000;
               cache_data_in      <= data[31:0];
               state              <= CHECK1;
            end
            CHECK1: if (!cache_busy) begin
               cache_enable       <= 1'b0;
               cache_write_enable <= 4'b0000;
               word1              <= cache_data_out;
               if (split) begin
                  cache_address <= {addr[31:2] + 30'd1, 2'b00};
                  state         <= ISSUE2;
               end else begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= write ? 32'b0 : extract({32'b0, cache_data_out});
                  state     <= RESP;
               end
            end
            ISSUE2: begin
               cache_enable       <= 1'b1;
               cache_write_enable <= write ? mask[7:4] : 4'b0000;
               cache_data_in      <= data[63:32];
               state              <= CHECK2;
            end
            CHECK2: if (!cache_busy) begin
               cache_enable       <= 1'b0;
               cache_write_enable <= 4'b0000;
               rsp_valid          <= 1'b1;
               rsp_rdata          <= write ? 32'b0 : extract({cache_data_out, word1});
               state              <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_port.sv
// tb_cache_port: random and directed load/store traffic against a byte-level
// reference memory; responses are checked by a scoreboard monitor.
module tb_cache_port;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        cache_enable;
   logic [31:0] cache_address, cache_data_in, cache_data_out;
   logic [3:0]  cache_write_enable;
   logic        cache_data_out_ready, cache_busy;

   typedef struct {logic [31:0] rdata; int acc; int lat;} exp_t;
   typedef struct {logic [31:0] a; logic [3:0] we; logic [31:0] d;} wr_t;
   exp_t        sb[$];
   wr_t         wlog[$];
   logic [7:0]  rmem [logic [31:0]];
   logic [31:0] cmem [logic [29:0]];
   int          errors = 0, checks = 0, cyc = 0, hold_end = 0;
   bit          rnd_busy = 0, prev_rv = 0;

   cache_port dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .cache_enable(cache_enable), .cache_address(cache_address),
      .cache_data_in(cache_data_in), .cache_write_enable(cache_write_enable),
      .cache_data_out(cache_data_out), .cache_data_out_ready(cache_data_out_ready),
      .cache_busy(cache_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
   endfunction

   function automatic logic [7:0] rb(input logic [31:0] a);
      return rmem.exists(a) ? rmem[a] : 8'h00;
   endfunction

   function automatic logic [31:0] cread(input logic [29:0] wa);
      return cmem.exists(wa) ? cmem[wa] : 32'h0;
   endfunction

   function automatic void ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      for (int i = 0; i < nbytes(sz); i++) rmem[a + 32'(i)] = wd[8*i +: 8];
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
      int n = nbytes(sz);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rb(a + 32'(i));
      if (!u && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic count_cycles();
      forever begin
         @(posedge clk);
         cyc++;
      end
   endtask

   // Cache stand-in: combinational read of the addressed word, writes on enabled, non-busy edges.
   task automatic cache_model();
      forever begin
         @(negedge clk);
         cache_busy     = (cyc < hold_end) || (rnd_busy && $urandom_range(0, 3) == 0);
         cache_data_out = cread(cache_address[31:2]);
      end
   endtask

   task automatic cache_writer();
      logic [31:0] w;
      forever begin
         @(posedge clk);
         if (rst_n && cache_enable && !cache_busy && cache_write_enable != 4'b0) begin
            w = cread(cache_address[31:2]);
            for (int k = 0; k < 4; k++) if (cache_write_enable[k]) w[8*k +: 8] = cache_data_in[8*k +: 8];
            cmem[cache_address[31:2]] = w;
            wlog.push_back('{cache_address, cache_write_enable, cache_data_in});
         end
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h, required no response", rsp_rdata);
            end else begin
               e = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               if (e.lat >= 0) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
            chk("rsp_one_cycle", {31'b0, prev_rv}, 32'h0);
         end
         prev_rv = rsp_valid;
      end
   endtask

   // extra < 0 leaves latency unchecked; resp = 0 means the access will be abandoned
   task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] wd, input int extra, input bit resp, output int n);
      int t = 0;
      bit sp;
      @(negedge clk);
      while (!req_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", {31'b0, req_ready}, 32'h1);
         n = -1;
         return;
      end
      req_valid = 1; req_addr = a; req_write = w; req_size = sz; req_unsigned = u; req_wdata = wd;
      @(posedge clk);
      #1;
      n = cyc;
      req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
      req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      if (resp) begin
         sp = int'(a[1:0]) + nbytes(sz) > 4;
         sb.push_back('{w ? 32'h0 : ref_load(a, sz, u), n, extra < 0 ? -1 : (sp ? 5 : 3) + extra});
         if (w) ref_store(a, sz, wd);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'h1);
      chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      chk({tag, "_cache_enable"}, {31'b0, cache_enable}, 32'h0);
      chk({tag, "_cache_address"}, cache_address, 32'h0);
      chk({tag, "_cache_data_in"}, cache_data_in, 32'h0);
      chk({tag, "_cache_we"}, {28'b0, cache_write_enable}, 32'h0);
   endtask

   initial begin
      int n, t;
      logic [31:0] a;
      req_valid = 0; req_addr = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_wdata = 0;
      cache_data_out = 0; cache_data_out_ready = 1; cache_busy = 0;
      rst_n = 1;
      fork
         count_cycles();
         cache_model();
         cache_writer();
         monitor();
         begin
            #2_000_000;
            $display("FAIL watchdog: simulation did not complete in time");
            $fatal(1);
         end
      join_none
      #1 rst_n = 0;
      #2 check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1;

      // word store then load, with cache-side signals checked per phase
      issue(32'h100, 1, 2'd2, 0, 32'hDEADBEEF, 0, 1, n);
      @(negedge clk);
      chk("st_issue_enable", {31'b0, cache_enable}, 32'h0);
      chk("st_issue_we", {28'b0, cache_write_enable}, 32'h0);
      chk("st_issue_addr", cache_address, 32'h100);
      @(negedge clk);
      chk("st_check_enable", {31'b0, cache_enable}, 32'h1);
      chk("st_check_we", {28'b0, cache_write_enable}, 32'hF);
      chk("st_check_data", cache_data_in, 32'hDEADBEEF);
      @(negedge clk);
      chk("st_after_we", {28'b0, cache_write_enable}, 32'h0);
      issue(32'h100, 0, 2'd2, 0, 32'h0, 0, 1, n);

      // sign and zero extension of sub-word loads
      issue(32'h200, 1, 2'd2, 0, 32'h80FF7F01, 0, 1, n);
      issue(32'h203, 0, 2'd0, 0, 32'h0, 0, 1, n);
      issue(32'h203, 0, 2'd0, 1, 32'h0, 0, 1, n);
      issue(32'h202, 0, 2'd1, 0, 32'h0, 0, 1, n);
      issue(32'h201, 0, 2'd3, 1, 32'h0, 0, 1, n);

      // split half store across 0x300/0x304
      repeat (4) @(negedge clk);
      wlog.delete();
      issue(32'h303, 1, 2'd1, 0, 32'h0000BBAA, 0, 1, n);
      repeat (6) @(negedge clk);
      chk("split_write_count", wlog.size(), 32'd2);
      if (wlog.size() >= 2) begin
         chk("split_p1_addr", wlog[0].a, 32'h300);
         chk("split_p1_mask", {28'b0, wlog[0].we}, 32'h8);
         chk("split_p1_data", wlog[0].d, 32'hAA000000);
         chk("split_p2_addr", wlog[1].a, 32'h304);
         chk("split_p2_mask", {28'b0, wlog[1].we}, 32'h1);
         chk("split_p2_data", wlog[1].d, 32'h000000BB);
      end
      issue(32'h303, 0, 2'd1, 0, 32'h0, 0, 1, n);

      // 20 busy cycles in CHECK1; busy also high during ISSUE1, where it must be ignored
      issue(32'h400, 1, 2'd2, 0, 32'h12345678, 0, 1, n);
      issue(32'h400, 0, 2'd2, 0, 32'h0, 20, 1, n);
      hold_end = n + 21;
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_enable", {31'b0, cache_enable}, 32'h1);
         chk("stall_addr", cache_address, 32'h400);
         chk("stall_we", {28'b0, cache_write_enable}, 32'h0);
      end

      // word load wrapping past the top of the address space
      issue(32'hFFFFFFFC, 1, 2'd2, 0, 32'h11223344, 0, 1, n);
      issue(32'h00000000, 1, 2'd2, 0, 32'h55667788, 0, 1, n);
      issue(32'hFFFFFFFE, 0, 2'd2, 0, 32'h0, 0, 1, n);
      repeat (3) @(negedge clk);
      chk("wrap_p2_addr", cache_address, 32'h0);

      // reset during CHECK1 of a store abandons it
      issue(32'h500, 1, 2'd2, 0, 32'hCAFEF00D, 0, 0, n);
      repeat (2) @(negedge clk);
      rst_n = 0;
      #1 check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_reset_ready", {31'b0, req_ready}, 32'h1);
      end
      issue(32'h500, 0, 2'd2, 0, 32'h0, 0, 1, n);

      // random traffic with random cache stalls
      rnd_busy = 1;
      for (int i = 0; i < 200; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 31))
                                         : 32'h1000 + 32'($urandom_range(0, 63));
         issue(a, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, -1, 1, n);
      end

      t = 0;
      while (sb.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", sb.size(), 32'd0);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
